vga_frame_reader: RTL and testbench
===================================

Name: vga_frame_reader

Overview:
Downstream consumer of the dual-port frame buffer. Generates 640x480@60 VGA timing from a 25 MHz pixel clock and drives the buffer's read port (addr_out, regread). Accepts the buffer's registered data_out and converts 2x-upscaled RGB565 pixels (320x240 image) to 12-bit RGB444 for the board DAC. All logic is in one clock domain.

Parameters:
AW, 17, read address width; must equal the frame buffer's AW
DW, 16, pixel width; RGB565 packing {R[15:11],G[10:5],B[4:0]}
IMG_W, 320, stored image width in pixels
IMG_H, 240, stored image height in pixels
H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48, horizontal timing in clocks
V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33, vertical timing in lines

Ports:
clk  in  1  pixel clock, 25 MHz
rst  in  1  synchronous reset, active-high
addr_out  out  AW  frame-buffer read address (to buffer addr_out)
regread  out  1  frame-buffer read enable (to buffer regread)
data_in  in  DW  pixel from buffer data_out; valid one clock after regread
vga_hsync  out  1  horizontal sync, active-low
vga_vsync  out  1  vertical sync, active-low
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
frame_start  out  1  one-clock pulse coincident with the first active pixel of each frame at the pins

Behaviour:
- Interface: one clock clk; rst is synchronous and active-high.
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL=800), v_cnt 0..V_TOTAL-1 (V_TOTAL=525). h_cnt wraps to 0 after 799, incrementing v_cnt; v_cnt wraps to 0 after 524. Frame = 420000 clocks.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. Image region: active and (h_cnt>>1)<IMG_W and (v_cnt>>1)<IMG_H.
- Addressing: addr = (v_cnt>>1)*IMG_W + (h_cnt>>1), computed incrementally with no multiplier: row_base register adds IMG_W at the start of each odd->even line transition; column offset increments every second active pixel. Each image row is fetched on two consecutive lines, and each pixel on two consecutive clocks.
- Pipeline, counter value (h,v) at cycle t:
  - t+1: addr_out/regread registered for (h,v); regread=1 only inside the image region, else 0, with addr_out held.
  - t+2: data_in valid.
  - t+3: vga_r/g/b, vga_hsync, vga_vsync, frame_start registered for (h,v).
  - Sync and region flags are delayed 3 stages to stay aligned.
- Colour: inside image, r=data_in[15:12], g=data_in[10:7], b=data_in[4:1]. Outside image or in blanking, RGB=0.
- Sync: hsync low for h in [656,751]; vsync low for v in [490,491]. Both negative polarity.
- Reset: counters, row_base and pipeline cleared. addr_out=0, regread=0, rgb=0, hsync=vsync=1, frame_start=0. Reset mid-frame aborts the frame; the first cycle after deassert is (0,0), and frame_start appears 3 clocks later.
- Last pixel (639,479) reads addr 239*320+319=76799. No address exceeds IMG_W*IMG_H-1.

Optional Feature:
VGA_TESTBAR_EN:
- Defined: adds input test_mode (1 bit). When test_mode=1, regread is forced 0 and RGB shows 8 vertical colour bars, each 80 px wide, in the order white, yellow, cyan, green, magenta, red, blue, black (4'hF/4'h0 per channel). Sync timing and latency are unchanged.
- Undefined: no test_mode port; RAM data only.

Test Plan:
- Reset held 5 clocks, then released -> addr_out=0 and regread=1 at cycle 1; vga_hsync=1; frame_start pulses at cycle 3; first rgb reflects ram[0].
- Buffer model returns addr as data -> line v=0 addresses 0,0,1,1,...,319,319; line v=1 repeats them; line v=2 starts at 320; the final active pixel reads 76799.
- Sync timing over 2 frames -> hsync low for 96 clocks of every 800; vsync low for exactly 1600 clocks (lines 490-491); frame_start period 420000 clocks.
- data_in=16'hF800 / 16'h07E0 / 16'h001F -> RGB at the pins = F,0,0 / 0,F,0 / 0,0,F, 3 clocks after the corresponding counter value; RGB=0 and regread=0 throughout blanking.
- rst asserted at (h=300, v=200) for 1 clock -> next cycle counters read (0,0) and outputs return to reset values; addresses restart at 0.
- With VGA_TESTBAR_EN and test_mode=1 -> regread stays 0; pixel x=0 is FFF, x=100 is FF0, x=639 is 000.

Source files
------------

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan-out from a dual-port frame buffer, 2x-upscaled RGB565 -> RGB444.
// Optional VGA_TESTBAR_EN adds a test_mode input that replaces RAM data with 8 colour bars.
module vga_frame_reader #(
  parameter int unsigned AW       = 17,
  parameter int unsigned DW       = 16,
  parameter int unsigned IMG_W    = 320,
  parameter int unsigned IMG_H    = 240,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic          clk,
  input  logic          rst,
`ifdef VGA_TESTBAR_EN
  input  logic          test_mode,
`endif
  output logic [AW-1:0] addr_out,
  output logic          regread,
  input  logic [DW-1:0] data_in,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_IMG    = HW'(IMG_W);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_IMG    = VW'(IMG_H);
  localparam logic [VW-1:0] V_IMG_LT = VW'(IMG_H - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [AW-1:0] row_base;

  logic active_c, in_img_c, hs_c, vs_c, fs_c;
  logic img_d1, hs_d1, vs_d1, fs_d1;
  logic img_d2, hs_d2, vs_d2, fs_d2;
  logic [3:0] r_c, g_c, b_c;
  logic unused_bits;

  assign unused_bits = ^{data_in[11], data_in[6:5], data_in[0]};

  // Region and sync decode for the current counter position
  always_comb begin
    active_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    in_img_c = active_c && ((h_cnt >> 1) < H_IMG) && ((v_cnt >> 1) < V_IMG);
    hs_c     = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
    vs_c     = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
    fs_c     = (h_cnt == '0) && (v_cnt == '0);
  end

  // Raster counters; row_base steps once per image row, after its second (odd) line
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      row_base <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt    <= '0;
        row_base <= '0;
      end else begin
        v_cnt <= v_cnt + VW'(1);
        if (v_cnt[0] && ((v_cnt >> 1) < V_IMG_LT))
          row_base <= row_base + ROW_STEP;
      end
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

`ifdef VGA_TESTBAR_EN
  logic       act_d1, act_d2, tm_d1, tm_d2;
  logic [2:0] bar_d1, bar_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_d1 <= 1'b0;
      act_d2 <= 1'b0;
      tm_d1  <= 1'b0;
      tm_d2  <= 1'b0;
      bar_d1 <= '0;
      bar_d2 <= '0;
    end else begin
      act_d1 <= active_c;
      act_d2 <= act_d1;
      tm_d1  <= test_mode;
      tm_d2  <= tm_d1;
      bar_d1 <= 3'(h_cnt / HW'(H_ACTIVE / 8));
      bar_d2 <= bar_d1;
    end
  end
  wire read_en_c = in_img_c && !test_mode;
`else
  wire read_en_c = in_img_c;
`endif

  // Stage 1: buffer read request; address holds outside the image
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_out <= '0;
      regread  <= 1'b0;
      img_d1   <= 1'b0;
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      fs_d1    <= 1'b0;
    end else begin
      regread <= read_en_c;
      if (in_img_c)
        addr_out <= row_base + AW'(h_cnt >> 1);
      img_d1 <= in_img_c;
      hs_d1  <= hs_c;
      vs_d1  <= vs_c;
      fs_d1  <= fs_c;
    end
  end

  // Stage 2: wait for buffer data
  always_ff @(posedge clk) begin
    if (rst) begin
      img_d2 <= 1'b0;
      hs_d2  <= 1'b1;
      vs_d2  <= 1'b1;
      fs_d2  <= 1'b0;
    end else begin
      img_d2 <= img_d1;
      hs_d2  <= hs_d1;
      vs_d2  <= vs_d1;
      fs_d2  <= fs_d1;
    end
  end

  // Colour selection for stage 3
  always_comb begin
    r_c = 4'h0;
    g_c = 4'h0;
    b_c = 4'h0;
`ifdef VGA_TESTBAR_EN
    if (tm_d2) begin
      if (act_d2) begin
        r_c = {4{~bar_d2[1]}};
        g_c = {4{~bar_d2[2]}};
        b_c = {4{~bar_d2[0]}};
      end
    end else
`endif
    if (img_d2) begin
      r_c = data_in[15:12];
      g_c = data_in[10:7];
      b_c = data_in[4:1];
    end
  end

  // Stage 3: pin registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= r_c;
      vga_g       <= g_c;
      vga_b       <= b_c;
      vga_hsync   <= hs_d2;
      vga_vsync   <= vs_d2;
      frame_start <= fs_d2;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader using a scaled raster (80x55 totals, 30x24 image) to keep frames short.
module tb_vga_frame_reader;

  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 48, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;   // 80
  localparam int VT = VA + VFP + VSY + VBP;   // 55
  localparam int IW = 30, IH = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] addr_out;
  logic        regread;
  logic [15:0] data_in = 16'h0;
  logic        vga_hsync, vga_vsync, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;
`ifdef VGA_TESTBAR_EN
  logic        test_mode = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int s     = 0;
  bit checking = 0;
  bit pat_mode = 0;
  logic [15:0] pat = 16'h0;
  int last_addr = 0;

  always #20 clk = ~clk;

  vga_frame_reader #(
    .IMG_W(IW), .IMG_H(IH),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef VGA_TESTBAR_EN
    .test_mode(test_mode),
`endif
    .addr_out(addr_out),
    .regread(regread),
    .data_in(data_in),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .frame_start(frame_start)
  );

  // Frame buffer with registered read port: pattern or address-as-data
  always @(posedge clk) if (regread) data_in <= pat_mode ? pat : addr_out[15:0];

  // Cycles since the last clock edge that sampled reset
  always @(posedge clk) if (rst) s <= 0; else s <= s + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s s=%0d got=%0h want=%0h", nm, s, act, exp);
    end
  endtask

  function automatic bit in_img(input int h, input int v);
    return (h < HA) && (v < VA) && (h / 2 < IW) && (v / 2 < IH);
  endfunction

  function automatic int pix_addr(input int h, input int v);
    return (v / 2) * IW + h / 2;
  endfunction

  function automatic logic [11:0] rgb_of(input logic [15:0] d);
    return {d[15:12], d[10:7], d[4:1]};
  endfunction

  // Reference model: every cycle, derive expected outputs from raster position
  always @(negedge clk) begin
    int k, h, v, a;
    logic [15:0] d;
    logic [11:0] e_pix;
    bit e_hs, e_vs, e_fs;
    if (checking) begin
      if (s == 0) begin
        last_addr = 0;
        chk("regread", 32'(regread), 32'd0);
        chk("addr", 32'(addr_out), 32'd0);
      end else begin
        k = s - 1;
        h = k % HT;
        v = (k / HT) % VT;
        if (in_img(h, v)) begin
          last_addr = pix_addr(h, v);
          chk("regread", 32'(regread), 32'd1);
        end else begin
          chk("regread", 32'(regread), 32'd0);
        end
        chk("addr", 32'(addr_out), 32'(last_addr));
      end
      if (s < 3) begin
        e_pix = 12'h000; e_hs = 1; e_vs = 1; e_fs = 0;
      end else begin
        k = s - 3;
        h = k % HT;
        v = (k / HT) % VT;
        e_hs = !(h >= HA + HFP && h < HA + HFP + HSY);
        e_vs = !(v >= VA + VFP && v < VA + VFP + VSY);
        e_fs = (h == 0) && (v == 0);
        if (in_img(h, v)) begin
          a = pix_addr(h, v);
          d = pat_mode ? pat : 16'(a);
          e_pix = rgb_of(d);
        end else begin
          e_pix = 12'h000;
        end
      end
      chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_pix));
      chk("hsync", 32'(vga_hsync), 32'(e_hs));
      chk("vsync", 32'(vga_vsync), 32'(e_vs));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
    end
  end

  // Sync and frame-period measurement between the first two frame_start pulses
  int abs_cyc = 0, fs_cnt = 0, fs_last = 0, fs_period = 0;
  int hl = 0, vl = 0, hl_frame = 0, vl_frame = 0;
  always @(negedge clk) begin
    abs_cyc++;
    if (!rst && frame_start === 1'b1) begin
      if (fs_cnt == 1) begin
        fs_period = abs_cyc - fs_last;
        hl_frame  = hl;
        vl_frame  = vl;
      end
      fs_cnt++;
      fs_last = abs_cyc;
      hl = 0;
      vl = 0;
    end
    if (vga_hsync === 1'b0) hl++;
    if (vga_vsync === 1'b0) vl++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(1);
    checking = 1;
    step(4);
    rst = 0;                                   // now s=0, counters (0,0)
    step(1);                                   // s=1
    chk("lit_addr_c1", 32'(addr_out), 32'd0);
    chk("lit_rr_c1", 32'(regread), 32'd1);
    chk("lit_hsync_c1", 32'(vga_hsync), 32'd1);
    step(2);                                   // s=3
    chk("lit_fs_c3", 32'(frame_start), 32'd1);
    chk("lit_addr_c3", 32'(addr_out), 32'd1);
    step(58);                                  // s=61: h=60 outside image
    chk("lit_rr_h60", 32'(regread), 32'd0);
    chk("lit_addr_hold", 32'(addr_out), 32'd29);
    step(20);                                  // s=81: (0,1) repeats row 0
    chk("lit_addr_v1", 32'(addr_out), 32'd0);
    step(80);                                  // s=161: (0,2)
    chk("lit_addr_v2", 32'(addr_out), 32'd30);
    step(3820 - 161);                          // s=3820: last image pixel (59,47)
    chk("lit_addr_last", 32'(addr_out), 32'd719);
    chk("lit_rr_last", 32'(regread), 32'd1);
    step(4000 - 3820);                         // vblank of frame 0
    pat_mode = 1; pat = 16'hF800;
    step(403);                                 // s=4403: frame 1 pixel (0,0)
    chk("lit_red", 32'({vga_r, vga_g, vga_b}), 32'h0F00);
    step(3997);
    pat = 16'h07E0;
    step(403);
    chk("lit_green", 32'({vga_r, vga_g, vga_b}), 32'h00F0);
    step(3997);
    pat = 16'h001F;
    step(403);                                 // s=13203
    chk("lit_blue", 32'({vga_r, vga_g, vga_b}), 32'h000F);
    step(14830 - 13203);                       // counters at (30,20)
    rst = 1;
    step(1);
    rst = 0;                                   // s=0 after mid-frame reset
    chk("lit_rst_addr", 32'(addr_out), 32'd0);
    chk("lit_rst_rr", 32'(regread), 32'd0);
    chk("lit_rst_hs", 32'(vga_hsync), 32'd1);
    chk("lit_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    step(1);
    chk("lit_restart_addr", 32'(addr_out), 32'd0);
    chk("lit_restart_rr", 32'(regread), 32'd1);
    step(2);
    chk("lit_restart_fs", 32'(frame_start), 32'd1);
    step(500);
    chk("fs_period", 32'(fs_period), 32'(HT * VT));
    chk("hsync_low_per_frame", 32'(hl_frame), 32'(HSY * VT));
    chk("vsync_low_per_frame", 32'(vl_frame), 32'(VSY * HT));
`ifdef VGA_TESTBAR_EN
    checking = 0;
    test_mode = 1;
    rst = 1;
    step(1);
    rst = 0;
    step(1);
    chk("bar_rr", 32'(regread), 32'd0);
    step(2);                                   // x=0
    chk("bar_x0", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
    step(12);                                  // x=12, bar 1
    chk("bar_x12", 32'({vga_r, vga_g, vga_b}), 32'hFF0);
    chk("bar_rr2", 32'(regread), 32'd0);
    step(51);                                  // x=63, bar 7
    chk("bar_x63", 32'({vga_r, vga_g, vga_b}), 32'h000);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
